pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use stalls, multi-cycle Ex stalls and branch redirect flushes.
// Optional stall statistics counter is built when PIPE_CTRL_STAT_EN is defined.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        ex_start,
  input  logic [4:0]  ex_cycles,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
`ifdef PIPE_CTRL_STAT_EN
  output logic        busy,
  output logic [31:0] stall_cyc
`else
  output logic        busy
`endif
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    EX_WAIT = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  localparam logic [5:0] STALL_ID = 6'b000111;
  localparam logic [5:0] STALL_EX = 6'b001111;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_cnt;
  logic [4:0]  w_cnt_nxt;
  logic [5:0]  w_stall;
  logic [31:0] r_new_pc;

  // Valid/ready is not used here: every request is a level or one-cycle pulse
  // sampled on the rising edge, and branch_flag always wins over everything else.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 6'b000000;
    case (r_state)
      RUN: begin
        if (branch_flag) begin
          w_state_nxt = FLUSH;
          w_cnt_nxt   = 5'd0;
        end else if (ex_start && (ex_cycles != 5'd0)) begin
          w_stall = STALL_EX;
          if (ex_cycles >= 5'd2) begin
            w_state_nxt = EX_WAIT;
            w_cnt_nxt   = ex_cycles - 5'd1;
          end
        end else if (stallreq_id) begin
          w_stall = STALL_ID;
        end
      end
      EX_WAIT: begin
        w_stall = STALL_EX;
        if (branch_flag) begin
          w_state_nxt = FLUSH;
          w_cnt_nxt   = 5'd0;
        end else if (r_cnt <= 5'd1) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = 5'd0;
        end else begin
          w_cnt_nxt = r_cnt - 5'd1;
        end
      end
      FLUSH: begin
        w_cnt_nxt   = 5'd0;
        w_state_nxt = branch_flag ? FLUSH : RUN;
      end
      default: begin
        w_state_nxt = RUN;
        w_cnt_nxt   = 5'd0;
      end
    endcase
    // Reset must silence the stall lines even before the first edge lands.
    if (rst) begin
      w_stall = 6'b000000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= RUN;
      r_cnt    <= 5'd0;
      r_new_pc <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (branch_flag) begin
        r_new_pc <= branch_target;
      end
    end
  end

  assign stall  = w_stall;
  assign flush  = (r_state == FLUSH);
  assign busy   = (r_state != RUN);
  assign new_pc = r_new_pc;

`ifdef PIPE_CTRL_STAT_EN
  logic [31:0] r_stall_cyc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cyc <= 32'h0;
    end else if (w_stall[0] && (r_stall_cyc != 32'hFFFF_FFFF)) begin
      r_stall_cyc <= r_stall_cyc + 32'd1;
    end
  end

  assign stall_cyc = r_stall_cyc;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed hazard scenarios followed by random traffic,
// compared cycle by cycle against a remaining-stall-cycles reference model.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_id;
  logic        ex_start;
  logic [4:0]  ex_cycles;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        busy;
`ifdef PIPE_CTRL_STAT_EN
  logic [31:0] stall_cyc;
`endif

  int n_chk;
  int n_err;

  // Reference model: outstanding Ex stall cycles after the current one,
  // a pending flush cycle, the last redirect target and the stall tally.
  int          m_wait;
  bit          m_flush;
  logic [31:0] m_pc;
  longint      m_stat;

  pipe_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_id   (stallreq_id),
    .ex_start      (ex_start),
    .ex_cycles     (ex_cycles),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .stall         (stall),
    .flush         (flush),
    .new_pc        (new_pc),
`ifdef PIPE_CTRL_STAT_EN
    .busy          (busy),
    .stall_cyc     (stall_cyc)
`else
    .busy          (busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic sr, input logic es, input logic [4:0] ec,
                     input logic bf, input logic [31:0] bt);
    logic [5:0] e_stall;
    @(negedge clk);
    rst           = r;
    stallreq_id   = sr;
    ex_start      = es;
    ex_cycles     = ec;
    branch_flag   = bf;
    branch_target = bt;
    #2;
    if (r)                    e_stall = 6'b000000;
    else if (m_flush)         e_stall = 6'b000000;
    else if (m_wait > 0)      e_stall = 6'b001111;
    else if (bf)              e_stall = 6'b000000;
    else if (es && ec != 0)   e_stall = 6'b001111;
    else if (sr)              e_stall = 6'b000111;
    else                      e_stall = 6'b000000;
    check("stall",  {26'd0, stall}, {26'd0, e_stall});
    check("flush",  {31'd0, flush}, {31'd0, m_flush});
    check("new_pc", new_pc, m_pc);
    check("busy",   {31'd0, busy}, {31'd0, (m_flush || m_wait > 0)});
`ifdef PIPE_CTRL_STAT_EN
    check("stall_cyc", stall_cyc, m_stat[31:0]);
`endif
    @(posedge clk);
    if (r) begin
      m_wait = 0; m_flush = 0; m_pc = 32'h0; m_stat = 0;
    end else begin
      if (e_stall[0] && m_stat < 64'hFFFF_FFFF) m_stat++;
      if (bf) begin
        m_flush = 1; m_wait = 0; m_pc = bt;
      end else if (m_flush) begin
        m_flush = 0;
      end else if (m_wait > 0) begin
        m_wait--;
      end else if (es && ec != 0) begin
        m_wait = int'(ec) - 1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 5'd0, 0, 32'h0);
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    m_wait = 0; m_flush = 0; m_pc = 32'h0; m_stat = 0;
    rst = 1'b1; stallreq_id = 1'b0; ex_start = 1'b0; ex_cycles = 5'd0;
    branch_flag = 1'b0; branch_target = 32'h0;
    repeat (2) @(posedge clk);

    // Reset held with requests active: stall must stay 0.
    cyc(1, 1, 1, 5'd4, 0, 32'h0);
    idle(1);

    // Load-use stall for three cycles.
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 5'd0, 0, 32'h0);
    idle(1);

    // Four-cycle Ex op, plus ignored requests inside EX_WAIT.
    cyc(0, 0, 1, 5'd4, 0, 32'h0);
    cyc(0, 1, 1, 5'd9, 0, 32'h0);
    idle(3);

    // S=0 ignored, S=1 single stall cycle.
    cyc(0, 0, 1, 5'd0, 0, 32'h0);
    cyc(0, 0, 1, 5'd1, 0, 32'h0);
    idle(1);

    // Redirect in the 2nd EX_WAIT cycle of a five-cycle op.
    cyc(0, 0, 1, 5'd5, 0, 32'h0);
    cyc(0, 0, 0, 5'd0, 0, 32'h0);
    cyc(0, 0, 0, 5'd0, 1, 32'h1C00_0040);
    cyc(0, 1, 1, 5'd3, 0, 32'h0);
    idle(2);

    // Branch and Ex start together: Ex dropped.
    cyc(0, 0, 1, 5'd6, 1, 32'h0000_0080);
    idle(3);

    // Back-to-back redirects.
    cyc(0, 0, 0, 5'd0, 1, 32'h0000_0100);
    cyc(0, 0, 0, 5'd0, 1, 32'h0000_0200);
    idle(2);

    // Reset in the middle of EX_WAIT when the count is 7.
    cyc(0, 0, 1, 5'd9, 0, 32'h0);
    cyc(0, 0, 0, 5'd0, 0, 32'h0);
    cyc(1, 1, 1, 5'd3, 0, 32'h0);
    cyc(1, 0, 0, 5'd0, 0, 32'h0);
    idle(2);

    // Reset during FLUSH.
    cyc(0, 0, 0, 5'd0, 1, 32'h0000_0300);
    cyc(1, 0, 0, 5'd0, 0, 32'h0);
    idle(1);

    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 49) == 0),
          ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 5) == 0),
          5'($urandom_range(0, 9)),
          ($urandom_range(0, 9) == 0),
          $urandom);
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
